dmem_arbiter: RTL and testbench

//  Shares the single data_memory port between two requesters (M0 = core LSU, M1 = debug/DMA).

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_arbiter_rr.sv | 18 +
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: access sizes, FSM states,
// latched request payload and size-based byte count / read-data masking.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic [DATA_W-1:0] wdata;
  } req_ctl_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size,
                                                  input logic [DATA_W-1:0] data);
    case (size)
      SIZE_B:  return {24'h0, data[7:0]};
      SIZE_H:  return {16'h0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins outright; on a tie or no request
// the side that did not win last time is offered the grant.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = last ? 2'b01 : 2'b10;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_memory port between the core LSU (M0) and debug/DMA (M1):
// round-robin grant, alignment/range check, one-cycle memory access, registered response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DROM_SPACE = 1024,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [31:0]       m0_req_wdata,
  input  logic [1:0]        m0_req_size,
  output logic              m0_rsp_valid,
  input  logic              m0_rsp_ready,
  output logic [31:0]       m0_rsp_rdata,
  output logic              m0_rsp_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [31:0]       m1_req_wdata,
  input  logic [1:0]        m1_req_size,
  output logic              m1_rsp_valid,
  input  logic              m1_rsp_ready,
  output logic [31:0]       m1_rsp_rdata,
  output logic              m1_rsp_err,

  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [1:0]        mem_byte_sel,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic              rr_last_q;
  logic              owner_q;
  req_ctl_t          lat_ctl_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [1:0]        rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [1:0]        gnt_c;
  logic [1:0]        req_ready_c;
  logic              hs_c;
  logic [EXT_W-1:0]  end_addr_c;
  logic              err_c;
  logic              access_ok_c;
  logic              rsp_ready_owner_c;

  rr_arbiter_2 u_rr (
    .req  ({m1_req_valid, m0_req_valid}),
    .last (rr_last_q),
    .gnt  (gnt_c)
  );

  // Ready is only offered while idle; reset suppresses it so nothing is accepted mid-reset.
  assign req_ready_c  = (state_q == IDLE && !rst) ? gnt_c : 2'b00;
  assign m0_req_ready = req_ready_c[0];
  assign m1_req_ready = req_ready_c[1];
  assign hs_c         = |(req_ready_c & {m1_req_valid, m0_req_valid});

  // End address is one bit wider than the address so a wrapping access still flags.
  assign end_addr_c = {1'b0, lat_addr_q} + EXT_W'(size_bytes(lat_ctl_q.size));
  assign err_c = (lat_ctl_q.size == SIZE_X)
              || (lat_ctl_q.size == SIZE_H && lat_addr_q[0])
              || (lat_ctl_q.size == SIZE_W && (|lat_addr_q[1:0]))
              || (end_addr_c > EXT_W'(DROM_SPACE));

  assign access_ok_c  = (state_q == ACCESS) && !err_c;
  assign mem_addr     = access_ok_c ? 32'(lat_addr_q) : 32'h0;
  assign mem_wdata    = access_ok_c ? lat_ctl_q.wdata : 32'h0;
  assign mem_byte_sel = access_ok_c ? lat_ctl_q.size : 2'b00;
  assign mem_w_en     = access_ok_c && lat_ctl_q.we;
  assign mem_r_en     = access_ok_c && !lat_ctl_q.we;

  assign rsp_ready_owner_c = owner_q ? m1_rsp_ready : m0_rsp_ready;

  assign m0_rsp_valid = rsp_valid_q[0];
  assign m1_rsp_valid = rsp_valid_q[1];
  assign m0_rsp_rdata = rsp_valid_q[0] ? rsp_rdata_q : 32'h0;
  assign m1_rsp_rdata = rsp_valid_q[1] ? rsp_rdata_q : 32'h0;
  assign m0_rsp_err   = rsp_valid_q[0] && rsp_err_q;
  assign m1_rsp_err   = rsp_valid_q[1] && rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs_c) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready_owner_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, round-robin history and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      lat_ctl_q   <= '0;
      lat_addr_q  <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (hs_c) begin
        owner_q   <= gnt_c[1];
        rr_last_q <= gnt_c[1];
        if (gnt_c[1]) begin
          lat_ctl_q  <= '{we: m1_req_we, size: m1_req_size, wdata: m1_req_wdata};
          lat_addr_q <= m1_req_addr;
        end else begin
          lat_ctl_q  <= '{we: m0_req_we, size: m0_req_size, wdata: m0_req_wdata};
          lat_addr_q <= m0_req_addr;
        end
      end
      if (state_q == ACCESS) begin
        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
        rsp_err_q   <= err_c;
        rsp_rdata_q <= (err_c || lat_ctl_q.we) ? 32'h0 : size_mask(lat_ctl_q.size, mem_rdata);
      end else if (state_q == RESP && rsp_ready_owner_c) begin
        rsp_valid_q <= 2'b00;
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model behind the port.
module tb_dmem_arbiter;

  localparam int unsigned DROM = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_req_we;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic [1:0]  m0_req_size;
  logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic [31:0] m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic [1:0]  m1_req_size;
  logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [31:0] m1_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_r_en, mem_w_en;
  logic [1:0]  mem_byte_sel;

  int errors = 0;
  int checks = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DROM_SPACE(DROM), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_size(m0_req_size),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_size(m1_req_size),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .m1_rsp_err(m1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_byte_sel(mem_byte_sel), .mem_rdata(mem_rdata)
  );

  // Little-endian byte memory: combinational read, write of 1/2/4 bytes on the clock edge.
  logic [7:0]  mem [DROM] = '{default: 8'h00};
  logic [31:0] a1, a2, a3;
  logic [7:0]  rb0, rb1, rb2, rb3;
  assign a1  = mem_addr + 32'd1;
  assign a2  = mem_addr + 32'd2;
  assign a3  = mem_addr + 32'd3;
  assign rb0 = (mem_addr < DROM) ? mem[mem_addr[9:0]] : 8'h00;
  assign rb1 = (a1 < DROM) ? mem[a1[9:0]] : 8'h00;
  assign rb2 = (a2 < DROM) ? mem[a2[9:0]] : 8'h00;
  assign rb3 = (a3 < DROM) ? mem[a3[9:0]] : 8'h00;
  assign mem_rdata = {rb3, rb2, rb1, rb0};

  always @(posedge clk) begin
    if (mem_w_en) begin
      for (int k = 0; k < 4; k++) begin
        int nb;
        logic [31:0] wa;
        nb = (mem_byte_sel == 2'b00) ? 1 : (mem_byte_sel == 2'b01) ? 2 : 4;
        wa = mem_addr + 32'(k);
        if (k < nb && wa < DROM) mem[wa[9:0]] <= mem_wdata[8*k +: 8];
      end
      wen_cnt <= wen_cnt + 1;
    end
    if (mem_r_en) ren_cnt <= ren_cnt + 1;
    if (mem_r_en && mem_w_en) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic set_req(input bit m, input bit v, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size);
    if (!m) begin
      m0_req_valid = v; m0_req_we = we; m0_req_addr = addr;
      m0_req_wdata = wdata; m0_req_size = size;
    end else begin
      m1_req_valid = v; m1_req_we = we; m1_req_addr = addr;
      m1_req_wdata = wdata; m1_req_size = size;
    end
  endtask

  // One complete transaction with rsp_ready held high; reports latency and enable counts.
  task automatic run_txn(input bit m, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int dw, output int dr, output logic other);
    int n, w0, r0;
    rdata = 32'hFFFF_FFFF; err = 1'b1; lat = -1; dw = -1; dr = -1; other = 1'b1;
    @(negedge clk);
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    set_req(m, 1'b1, we, addr, wdata, size);
    #1;
    n = 0;
    while (!(m ? m1_req_ready : m0_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      timeout("txn_req_ready");
      set_req(m, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      return;
    end
    w0 = wen_cnt; r0 = ren_cnt;
    @(posedge clk);
    @(negedge clk);
    set_req(m, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    lat = 1;
    while (!(m ? m1_rsp_valid : m0_rsp_valid) && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    rdata = m ? m1_rsp_rdata : m0_rsp_rdata;
    err   = m ? m1_rsp_err : m0_rsp_err;
    other = m ? m0_rsp_valid : m1_rsp_valid;
    dw = wen_cnt - w0;
    dr = ren_cnt - r0;
    @(posedge clk);
  endtask

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic        er, oth;
    int          lat, dw, dr;
    string       tag;

    vecs[0]  = '{0, 1, 32'h10,       32'hDEADBEEF, 2'b10, 32'h0,        0};
    vecs[1]  = '{0, 0, 32'h10,       32'h0,        2'b10, 32'hDEADBEEF, 0};
    vecs[2]  = '{0, 0, 32'h11,       32'h0,        2'b00, 32'h000000BE, 0};
    vecs[3]  = '{0, 0, 32'h12,       32'h0,        2'b01, 32'h0000DEAD, 0};
    vecs[4]  = '{1, 0, 32'h10,       32'h0,        2'b10, 32'hDEADBEEF, 0};
    vecs[5]  = '{1, 1, 32'h40,       32'hAABBCCDD, 2'b00, 32'h0,        0};
    vecs[6]  = '{1, 0, 32'h40,       32'h0,        2'b10, 32'h000000DD, 0};
    vecs[7]  = '{0, 1, 32'h42,       32'h11223344, 2'b01, 32'h0,        0};
    vecs[8]  = '{1, 0, 32'h40,       32'h0,        2'b10, 32'h334400DD, 0};
    vecs[9]  = '{0, 0, 32'h13,       32'h0,        2'b10, 32'h0,        1};
    vecs[10] = '{0, 0, 32'h11,       32'h0,        2'b01, 32'h0,        1};
    vecs[11] = '{1, 1, 32'h3FE,      32'hDEADBEEF, 2'b10, 32'h0,        1};
    vecs[12] = '{0, 0, 32'h3FE,      32'h0,        2'b01, 32'h0,        0};
    vecs[13] = '{0, 0, 32'h3FF,      32'h0,        2'b00, 32'h0,        0};
    vecs[14] = '{1, 0, 32'h400,      32'h0,        2'b00, 32'h0,        1};
    vecs[15] = '{0, 0, 32'hFFFFFFFC, 32'h0,        2'b10, 32'h0,        1};
    vecs[16] = '{1, 0, 32'h0,        32'h0,        2'b11, 32'h0,        1};
    vecs[17] = '{0, 1, 32'h3FC,      32'hCAFEF00D, 2'b10, 32'h0,        0};
    vecs[18] = '{1, 0, 32'h3FC,      32'h0,        2'b10, 32'hCAFEF00D, 0};
    vecs[19] = '{0, 1, 32'h3FC,      32'h00000055, 2'b00, 32'h0,        0};

    rst = 1'b1;
    m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", 32'(m0_req_ready), 32'd0);
    chk("rst_ready1", 32'(m1_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
    chk("rst_mem_en", 32'({mem_r_en, mem_w_en}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_ready0", 32'(m0_req_ready), 32'd1);
    chk("idle_ready1", 32'(m1_req_ready), 32'd0);

    // Table of single transactions
    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size,
              rd, er, lat, dw, dr, oth);
      tag = $sformatf("v%0d", i);
      chk({tag, "_latency"}, 32'(lat), 32'd2);
      chk({tag, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({tag, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      chk({tag, "_w_en_cycles"}, 32'(dw), (!vecs[i].exp_err && vecs[i].we) ? 32'd1 : 32'd0);
      chk({tag, "_r_en_cycles"}, 32'(dr), (!vecs[i].exp_err && !vecs[i].we) ? 32'd1 : 32'd0);
      chk({tag, "_other_rsp"}, 32'(oth), 32'd0);
    end
    run_txn(1, 0, 32'h3FC, 32'h0, 2'b10, rd, er, lat, dw, dr, oth);
    chk("byte_store_merge", rd, 32'hCAFEF055);

    // Both requesters continuously valid: grants alternate and responses go to owners
    begin
      int n0, n1, r0, r1, cyc;
      bit exp_m, g0, g1;
      n0 = 0; n1 = 0; r0 = 0; r1 = 0; cyc = 0; exp_m = 1'b0;
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
      set_req(1, 1'b1, 1'b0, 32'h11, 32'h0, 2'b00);
      while ((r0 < 4 || r1 < 4) && cyc < 200) begin
        #1;
        if (m0_rsp_valid && m1_rsp_valid) chk("arb_dual_rsp", 32'd1, 32'd0);
        if (m0_rsp_valid) begin chk("arb_rsp0", m0_rsp_rdata, 32'hDEADBEEF); r0++; end
        if (m1_rsp_valid) begin chk("arb_rsp1", m1_rsp_rdata, 32'h000000BE); r1++; end
        g0 = m0_req_valid && m0_req_ready;
        g1 = m1_req_valid && m1_req_ready;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (g0 || g1) begin
          chk("arb_order", 32'(g1), 32'(exp_m));
          exp_m = ~exp_m;
        end
        if (g0) begin n0++; if (n0 == 4) m0_req_valid = 1'b0; end
        if (g1) begin n1++; if (n1 == 4) m1_req_valid = 1'b0; end
      end
      if (cyc >= 200) timeout("arb_sequence");
      chk("arb_grants0", 32'(n0), 32'd4);
      chk("arb_grants1", 32'(n1), 32'd4);
    end

    // Response backpressure blocks the other requester and holds data stable
    @(negedge clk);
    m0_rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
    #1;
    chk("bp_grant0", 32'({m1_req_ready, m0_req_ready}), 32'd1);
    @(posedge clk);
    @(negedge clk);
    m0_req_valid = 1'b0;
    @(negedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", 32'(m0_rsp_valid), 32'd1);
      chk("bp_rsp_rdata", m0_rsp_rdata, 32'hDEADBEEF);
      chk("bp_m1_ready", 32'(m1_req_ready), 32'd0);
      @(negedge clk); #1;
    end
    m0_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("bp_released_rsp", 32'(m0_rsp_valid), 32'd0);
    chk("bp_released_m1", 32'(m1_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    m1_req_valid = 1'b0;
    begin
      int n;
      n = 0;
      #1;
      while (!m1_rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) timeout("bp_m1_rsp");
      chk("bp_m1_rdata", m1_rsp_rdata, 32'h334400DD);
    end
    @(posedge clk);

    // Reset while a store is in ACCESS: store lands, response is dropped
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 2'b10);
    #1;
    chk("rst_mid_grant", 32'(m0_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    chk("rst_mid_w_en", 32'(mem_w_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mid_mem_en", 32'({mem_r_en, mem_w_en}), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'h0);
    chk("rst_mid_rsp", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
    chk("rst_mid_ready", 32'({m1_req_ready, m0_req_ready}), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_dropped_rsp", 32'({m1_rsp_valid, m0_rsp_valid}), 32'd0);
    end
    run_txn(0, 0, 32'h20, 32'h0, 2'b10, rd, er, lat, dw, dr, oth);
    chk("rst_store_kept", rd, 32'h12345678);
    chk("rst_store_err", 32'(er), 32'd0);

    chk("never_both_enables", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
